// File: rtl/parity_scan_pkg.sv
// Shared types and constants for the 8x8 grid parity scan controller.
// The optional correction output is enabled by defining PARITY_CORRECT_EN.
package parity_scan_pkg;

    localparam int GRID_N   = 8;
    localparam int IDX_W    = 3;
    localparam int SCAN_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROWS = 2'd1,
        COLS = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_onehot8(input logic [GRID_N-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < GRID_N; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

    // Index of the highest set bit; only meaningful when v is one-hot.
    function automatic logic [IDX_W-1:0] onehot_idx8(input logic [GRID_N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < GRID_N; i++) begin
            if (v[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/paritycheck.sv
// 8-bit parity checker: parity is 1 when an odd number of input bits are set.
module paritycheck (
    input  logic [7:0] data,
    output logic       parity
);

    assign parity = ^data;

endmodule

// File: rtl/parity_scan_ctrl.sv
// Time-shares one paritycheck over the rows then columns of a latched 8x8 grid,
// builds the row/column syndrome and classifies it. PARITY_CORRECT_EN adds fixed_grid.
module parity_scan_ctrl
    import parity_scan_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [63:0]             grid,
    input  logic [GRID_N-1:0]       exp_row_par,
    input  logic [GRID_N-1:0]       exp_col_par,
    output logic                    busy,
    output logic                    done,
    output logic [GRID_N-1:0]       row_err,
    output logic [GRID_N-1:0]       col_err,
    output logic                    clean,
    output logic                    single_err,
    output logic                    multi_err,
    output logic [IDX_W-1:0]        err_row,
    output logic [IDX_W-1:0]        err_col,
`ifdef PARITY_CORRECT_EN
    output logic [63:0]             fixed_grid,
`endif
    output state_e                  state_dbg
);

    // Handshake: start is a level sampled on the rising edge only while IDLE;
    // done is a single-cycle pulse and results stay valid until the next accepted start.

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [63:0]            grid_q, grid_d;
    logic [GRID_N-1:0]      exp_row_q, exp_row_d;
    logic [GRID_N-1:0]      exp_col_q, exp_col_d;
    logic [GRID_N-1:0]      row_err_q, row_err_d;
    logic [GRID_N-1:0]      col_err_q, col_err_d;
    logic                   clean_q, clean_d;
    logic                   single_q, single_d;
    logic                   multi_q, multi_d;
    logic [IDX_W-1:0]       err_row_q, err_row_d;
    logic [IDX_W-1:0]       err_col_q, err_col_d;
`ifdef PARITY_CORRECT_EN
    logic [63:0]            fixed_q, fixed_d;
`endif

    logic [GRID_N-1:0]      chk_data;
    logic                   chk_par;
    logic                   row_single;
    logic                   col_single;

    // Column idx gathers bit idx of every row: grid[8i+idx].
    always_comb begin
        chk_data = '0;
        case (state_q)
            ROWS: chk_data = grid_q[{idx_q, 3'b000} +: GRID_N];
            COLS: begin
                for (int i = 0; i < GRID_N; i++) begin
                    chk_data[i] = grid_q[{i[IDX_W-1:0], idx_q}];
                end
            end
            default: chk_data = '0;
        endcase
    end

    paritycheck u_paritycheck (
        .data   (chk_data),
        .parity (chk_par)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        grid_d     = grid_q;
        exp_row_d  = exp_row_q;
        exp_col_d  = exp_col_q;
        row_err_d  = row_err_q;
        col_err_d  = col_err_q;
        clean_d    = clean_q;
        single_d   = single_q;
        multi_d    = multi_q;
        err_row_d  = err_row_q;
        err_col_d  = err_col_q;
`ifdef PARITY_CORRECT_EN
        fixed_d    = fixed_q;
`endif
        row_single = 1'b0;
        col_single = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ROWS;
                    idx_d     = '0;
                    grid_d    = grid;
                    exp_row_d = exp_row_par;
                    exp_col_d = exp_col_par;
                    row_err_d = '0;
                    col_err_d = '0;
                    clean_d   = 1'b0;
                    single_d  = 1'b0;
                    multi_d   = 1'b0;
                    err_row_d = '0;
                    err_col_d = '0;
`ifdef PARITY_CORRECT_EN
                    fixed_d   = '0;
`endif
                end
            end
            ROWS: begin
                row_err_d[idx_q] = chk_par ^ exp_row_q[idx_q];
                idx_d            = idx_q + 1'b1;
                if (idx_q == IDX_W'(GRID_N - 1)) begin
                    state_d = COLS;
                end
            end
            COLS: begin
                col_err_d[idx_q] = chk_par ^ exp_col_q[idx_q];
                idx_d            = idx_q + 1'b1;
                if (idx_q == IDX_W'(GRID_N - 1)) begin
                    // Classify on the final column write so results are registered for the DONE cycle.
                    state_d    = DONE;
                    row_single = is_onehot8(row_err_q);
                    col_single = is_onehot8(col_err_d);
                    clean_d    = (row_err_q == '0) && (col_err_d == '0);
                    single_d   = row_single && col_single;
                    multi_d    = !((row_err_q == '0) && (col_err_d == '0)) && !(row_single && col_single);
                    err_row_d  = (row_single && col_single) ? onehot_idx8(row_err_q) : '0;
                    err_col_d  = (row_single && col_single) ? onehot_idx8(col_err_d) : '0;
`ifdef PARITY_CORRECT_EN
                    fixed_d    = grid_q;
                    if (row_single && col_single) begin
                        fixed_d[{onehot_idx8(row_err_q), onehot_idx8(col_err_d)}] =
                            ~grid_q[{onehot_idx8(row_err_q), onehot_idx8(col_err_d)}];
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            grid_q    <= '0;
            exp_row_q <= '0;
            exp_col_q <= '0;
            row_err_q <= '0;
            col_err_q <= '0;
            clean_q   <= 1'b0;
            single_q  <= 1'b0;
            multi_q   <= 1'b0;
            err_row_q <= '0;
            err_col_q <= '0;
`ifdef PARITY_CORRECT_EN
            fixed_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            grid_q    <= grid_d;
            exp_row_q <= exp_row_d;
            exp_col_q <= exp_col_d;
            row_err_q <= row_err_d;
            col_err_q <= col_err_d;
            clean_q   <= clean_d;
            single_q  <= single_d;
            multi_q   <= multi_d;
            err_row_q <= err_row_d;
            err_col_q <= err_col_d;
`ifdef PARITY_CORRECT_EN
            fixed_q   <= fixed_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign row_err    = row_err_q;
    assign col_err    = col_err_q;
    assign clean      = clean_q;
    assign single_err = single_q;
    assign multi_err  = multi_q;
    assign err_row    = err_row_q;
    assign err_col    = err_col_q;
`ifdef PARITY_CORRECT_EN
    assign fixed_grid = fixed_q;
`endif
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Directed self-checking bench for parity_scan_ctrl; define PARITY_CORRECT_EN to cover fixed_grid.
module tb_parity_scan_ctrl;
  import parity_scan_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] grid;
  logic [7:0]  exp_row_par;
  logic [7:0]  exp_col_par;
  logic        busy;
  logic        done;
  logic [7:0]  row_err;
  logic [7:0]  col_err;
  logic        clean;
  logic        single_err;
  logic        multi_err;
  logic [2:0]  err_row;
  logic [2:0]  err_col;
  logic [63:0] fixed_grid;
  state_e      state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  parity_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .grid        (grid),
    .exp_row_par (exp_row_par),
    .exp_col_par (exp_col_par),
    .busy        (busy),
    .done        (done),
    .row_err     (row_err),
    .col_err     (col_err),
    .clean       (clean),
    .single_err  (single_err),
    .multi_err   (multi_err),
    .err_row     (err_row),
    .err_col     (err_col),
`ifdef PARITY_CORRECT_EN
    .fixed_grid  (fixed_grid),
`endif
    .state_dbg   (state_dbg)
  );

`ifndef PARITY_CORRECT_EN
  assign fixed_grid = '0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    check_eq({tag, ".done"}, 64'(done), 64'd0);
    check_eq({tag, ".row_err"}, 64'(row_err), 64'd0);
    check_eq({tag, ".col_err"}, 64'(col_err), 64'd0);
    check_eq({tag, ".flags"}, 64'({clean, single_err, multi_err}), 64'd0);
    check_eq({tag, ".err_idx"}, 64'({err_row, err_col}), 64'd0);
    check_eq({tag, ".fixed"}, fixed_grid, 64'd0);
    check_eq({tag, ".state"}, 64'(state_dbg), 64'(IDLE));
  endtask

  // driver: start one scan, optionally pulse a stray start at cycle pulse_at,
  // then check partial progress, latency and the held results.
  task automatic run_scan(input string tag, input logic [63:0] g, input logic [7:0] er, input logic [7:0] ec,
                          input logic [7:0] x_row, input logic [7:0] x_col, input logic [2:0] x_flags,
                          input logic [2:0] x_r, input logic [2:0] x_c, input logic [63:0] x_fixed,
                          input int pulse_at);
    int cyc;
    bit got;
    @(negedge clk);
    grid = g; exp_row_par = er; exp_col_par = ec; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    grid = ~g; exp_row_par = ~er; exp_col_par = ~ec;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == 9) begin
        check_eq({tag, ".mid_busy"}, 64'(busy), 64'd1);
        check_eq({tag, ".mid_row_err"}, 64'(row_err), 64'(x_row));
        check_eq({tag, ".mid_col_err"}, 64'(col_err), 64'd0);
        check_eq({tag, ".mid_flags"}, 64'({clean, single_err, multi_err}), 64'd0);
      end
      if (done) got = 1;
    end
    start = 1'b0;
    check_eq({tag, ".done_seen"}, 64'(got), 64'd1);
    check_eq({tag, ".latency"}, 64'(cyc), 64'd17);
    check_eq({tag, ".busy_at_done"}, 64'(busy), 64'd1);
    check_eq({tag, ".row_err"}, 64'(row_err), 64'(x_row));
    check_eq({tag, ".col_err"}, 64'(col_err), 64'(x_col));
    check_eq({tag, ".flags"}, 64'({clean, single_err, multi_err}), 64'(x_flags));
    check_eq({tag, ".err_row"}, 64'(err_row), 64'(x_r));
    check_eq({tag, ".err_col"}, 64'(err_col), 64'(x_c));
`ifdef PARITY_CORRECT_EN
    check_eq({tag, ".fixed"}, fixed_grid, x_fixed);
`endif
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, ".busy_after"}, 64'(busy), 64'd0);
    check_eq({tag, ".hold"}, 64'({row_err, col_err, clean, single_err, multi_err, err_row, err_col}),
             64'({x_row, x_col, x_flags, x_r, x_c}));
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq({tag, ".no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; grid = '0; exp_row_par = '0; exp_col_par = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // flags are {clean, single_err, multi_err}
    run_scan("zero", 64'h0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 3'd0, 3'd0, 64'h0, 0);
    run_scan("cell35", 64'h0000_0000_2000_0000, 8'h00, 8'h00, 8'h08, 8'h20, 3'b010, 3'd3, 3'd5, 64'h0, 0);
    run_scan("cells21_26", 64'h0000_0000_0042_0000, 8'h00, 8'h00, 8'h00, 8'h42, 3'b001, 3'd0, 3'd0,
             64'h0000_0000_0042_0000, 0);
    run_scan("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 3'd0, 3'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 0);
    // Error induced purely by expected parities: row 0 / column 7 corner.
    run_scan("exp_corner", 64'h0, 8'h01, 8'h80, 8'h01, 8'h80, 3'b010, 3'd0, 3'd7, 64'h0000_0000_0000_0080, 0);
    // Two row errors, no column errors.
    run_scan("two_rows", 64'h0100_0000_0000_0001, 8'h00, 8'h00, 8'h81, 8'h00, 3'b001, 3'd0, 3'd0,
             64'h0100_0000_0000_0001, 0);
    // Stray start at cycle 5 is ignored: one done at 17, original results, no second scan.
    run_scan("busy_start", 64'h0000_0000_2000_0000, 8'h00, 8'h00, 8'h08, 8'h20, 3'b010, 3'd3, 3'd5, 64'h0, 5);
    expect_no_done("busy_start", 20);

    // Reset at cycle 10 of a scan.
    @(negedge clk);
    grid = 64'h0000_0000_2000_0000; exp_row_par = '0; exp_col_par = '0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_reset.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("mid_reset", 25);
    run_scan("after_reset", 64'h0000_0000_0042_0000, 8'h00, 8'h00, 8'h00, 8'h42, 3'b001, 3'd0, 3'd0,
             64'h0000_0000_0042_0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/parity_scan_ctrl.md
# parity_scan_ctrl

Sequencing controller that time-shares one `paritycheck` instance across the 8 rows and 8 columns of an 8×8 bit grid. It compares each computed parity against the supplied expected row/column parity and builds a 16-bit error syndrome. It then classifies the result as clean, single-bit (locatable) or multi-bit. It sits between the grid store and the puzzle/decoder logic that consumes the check result.

## Interface
Parameters:
- none; grid fixed at 8×8, matching the 8-bit `paritycheck` datapath.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request scan; accepted only in IDLE.
- grid  in  64  row r = grid[8r+7:8r]; cell (r,c) = grid[8r+c]; sampled on accepted start.
- exp_row_par  in  8  expected parity of row r at bit r; sampled with grid.
- exp_col_par  in  8  expected parity of column c at bit c; sampled with grid.
- busy  out  1  high from accepted start until done cycle inclusive.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- row_err  out  8  bit r = computed parity of row r ≠ exp_row_par[r].
- col_err  out  8  bit c = computed parity of column c ≠ exp_col_par[c].
- clean  out  1  row_err==0 and col_err==0.
- single_err  out  1  exactly one row_err bit and exactly one col_err bit set.
- multi_err  out  1  neither clean nor single_err.
- err_row  out  3  index of set row_err bit when single_err, else 0.
- err_col  out  3  index of set col_err bit when single_err, else 0.
- fixed_grid  out  64  present only with PARITY_CORRECT_EN (see Configuration).

## Operation
- Parity = XOR of the 8 selected bits (odd count → 1), as produced by `paritycheck`.
- FSM states: IDLE, ROWS, COLS, DONE.
  - IDLE: on start=1, latch grid/exp_row_par/exp_col_par, clear row_err/col_err, set idx=0, go ROWS.
  - ROWS: feed row idx to checker; write row_err[idx]; idx+1; after idx=7, set idx=0 and go COLS.
  - COLS: feed column idx (bit i = latched grid[8i+idx]) to checker; write col_err[idx]; after idx=7, go DONE.
  - DONE: assert done for one cycle, compute classification, go IDLE.
- idx is a 3-bit counter; it wraps 7→0 at the ROWS→COLS transition.
- start while busy (ROWS/COLS/DONE) is ignored, not queued. Input changes during a scan have no effect.
- Result outputs (row_err, col_err, clean, single_err, multi_err, err_row, err_col) hold from done until the next accepted start.
- Between the accepted start and done, row_err/col_err show partial progress. Classification flags are forced 0 during that interval.

## Timing
- Reset values: busy=0, done=0, row_err=0, col_err=0, clean=0, single_err=0, multi_err=0, err_row=0, err_col=0, fixed_grid=0; state IDLE, idx=0.
- The start accepted at edge E0 processes rows on edges E1–E8 and columns on E9–E16. done=1 in the cycle following E16, so latency from the start edge to done is 17 cycles.
- busy rises after E0 and falls after E17.
- A new start can be accepted on E18 at the earliest (first IDLE cycle). Back-to-back scans therefore take 18 cycles each.
- Reset asserted mid-scan aborts the scan immediately. All outputs return to their reset values, and no done pulse is produced.

## Configuration
- PARITY_CORRECT_EN defined:
  - Adds the fixed_grid port.
  - In the DONE cycle, fixed_grid = latched grid with cell (err_row, err_col) inverted if single_err, otherwise latched grid unchanged.
  - fixed_grid holds like the other results.
- PARITY_CORRECT_EN undefined: the fixed_grid port and correction logic are absent. All other behaviour is identical.

## Structure
- Package parity_scan_pkg holds:
  - the state enum (IDLE, ROWS, COLS, DONE);
  - constants GRID_N=8, IDX_W=3 and SCAN_LEN=16.
- One sub-module: the existing `paritycheck`, instantiated exactly once. Its input is muxed from the latched grid by state and idx.

## Test plan
- Grid 64'h0, exp parities 0, start → done at 17 cycles; clean=1, row_err=0, col_err=0.
- Grid with only cell (3,5) set, exp parities 0 → row_err=8'h08, col_err=8'h20, single_err=1, err_row=3, err_col=5; with PARITY_CORRECT_EN, fixed_grid=0.
- Cells (2,1) and (2,6) set, exp 0 → row_err=0, col_err=8'h42, multi_err=1, err_row=0, err_col=0.
- Grid 64'hFFFF_FFFF_FFFF_FFFF, exp parities 0 → clean=1 (each line has 8 ones, so even parity).
- Pulse start again at cycle 5 of a scan → ignored; exactly one done, at cycle 17.
- Assert rst_n=0 at cycle 10 of a scan → busy=0 and all results 0 immediately; no done. After release, a new start produces correct results.
